env_adsr: RTL

- Linear ADSR envelope generator producing the gain word for the VCA multiplier's B operand (vca_in_b), one instance per voice.
- Advances once per audio-sample strobe from the I2S frame logic.
- Output is a non-negative Q1.15 gain (0x0000..0x7FFF), so the signed 16x16 multiply in the VCA never sees a negative gain.

---
 rtl/zm_env_pkg.sv | 18 +
 rtl/env_sat_step.sv | 38 +++
 rtl/env_adsr.sv | 130 +++++++++++++
 3 files changed

// File: rtl/zm_env_pkg.sv
// Shared envelope types and constants.
// State codes are visible on env_state for debug.
package zm_env_pkg;

   localparam int ACC_W_DEF  = 24;
   localparam int RATE_W_DEF = 16;

   localparam logic [15:0] ENV_MAX = 16'h7FFF;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ATTACK  = 3'd1,
      DECAY   = 3'd2,
      SUSTAIN = 3'd3,
      RELEASE = 3'd4
   } env_state_t;

endpackage

// File: rtl/env_sat_step.sv
// Saturating accumulator step toward a target.
// Zero rate snaps straight onto the target.
module env_sat_step #(
   parameter int ACC_W = 24
) (
   input  logic [ACC_W-1:0] acc,
   input  logic [ACC_W-1:0] rate,
   input  logic [ACC_W-1:0] target,
   input  logic             up,
   output logic [ACC_W-1:0] next_acc,
   output logic             reached
);

   logic [ACC_W:0] sum;
   logic [ACC_W:0] diff;

   // Guard-bit add/sub, clamped so the result never passes the target
   always_comb begin
      sum      = {1'b0, acc} + {1'b0, rate};
      diff     = {1'b0, acc} - {1'b0, rate};
      next_acc = target;
      reached  = 1'b1;
      if (rate != '0) begin
         if (up) begin
            if (sum < {1'b0, target}) begin
               next_acc = sum[ACC_W-1:0];
               reached  = 1'b0;
            end
         end else begin
            if (!diff[ACC_W] && (diff > {1'b0, target})) begin
               next_acc = diff[ACC_W-1:0];
               reached  = 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/env_adsr.sv
// Linear ADSR envelope, one per voice.
// Emits a non-negative Q1.15 gain for the VCA.
module env_adsr
   import zm_env_pkg::*;
#(
   parameter int ACC_W  = ACC_W_DEF,
   parameter int RATE_W = RATE_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sample_tick,
   input  logic              gate,
   input  logic [RATE_W-1:0] attack_rate,
   input  logic [RATE_W-1:0] decay_rate,
   input  logic [14:0]       sustain_level,
   input  logic [RATE_W-1:0] release_rate,
   output logic [15:0]       env_out,
   output logic              env_active,
   output logic [2:0]        env_state
);

   localparam logic [ACC_W-1:0] ACC_MAX = '1;

   env_state_t       state;
   logic [ACC_W-1:0] acc;
   logic             gate_d;

   logic             rise;
   logic             fall;
   logic [ACC_W-1:0] sus_t;
   logic [ACC_W-1:0] step_rate;
   logic [ACC_W-1:0] step_tgt;
   logic             step_up;
   logic [ACC_W-1:0] step_acc;
   logic             step_hit;
   logic [14:0]      level;

   assign rise  = gate & ~gate_d;
   assign fall  = ~gate & gate_d;
   assign sus_t = {sustain_level, {(ACC_W-15){1'b0}}};
   assign level = acc[ACC_W-1 -: 15];

   // Pick rate, target and direction for the current phase
   always_comb begin
      step_rate = '0;
      step_tgt  = '0;
      step_up   = 1'b0;
      unique case (state)
         ATTACK: begin
            step_rate = ACC_W'(attack_rate);
            step_tgt  = ACC_MAX;
            step_up   = 1'b1;
         end
         DECAY: begin
            step_rate = ACC_W'(decay_rate);
            step_tgt  = sus_t;
         end
         RELEASE: begin
            step_rate = ACC_W'(release_rate);
         end
         default: begin
            step_rate = '0;
         end
      endcase
   end

   env_sat_step #(
      .ACC_W (ACC_W)
   ) u_step (
      .acc      (acc),
      .rate     (step_rate),
      .target   (step_tgt),
      .up       (step_up),
      .next_acc (step_acc),
      .reached  (step_hit)
   );

   // Envelope FSM; gate edges win over the tick step
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         acc        <= '0;
         gate_d     <= 1'b0;
         env_out    <= 16'h0000;
         env_active <= 1'b0;
         env_state  <= IDLE;
      end else begin
         gate_d     <= gate;
         env_out    <= ENV_MAX & {1'b0, level};
         env_active <= (state != IDLE);
         env_state  <= state;
         if (rise) begin
            state <= ATTACK;
         end else if (fall) begin
            if (state == ATTACK || state == DECAY ||
                state == SUSTAIN)
               state <= RELEASE;
         end else if (sample_tick) begin
            unique case (state)
               IDLE: begin
                  acc <= '0;
               end
               ATTACK: begin
                  acc <= step_acc;
                  if (step_hit)
                     state <= DECAY;
               end
               DECAY: begin
                  acc <= step_acc;
                  if (step_hit)
                     state <= SUSTAIN;
               end
               SUSTAIN: begin
                  acc <= sus_t;
               end
               RELEASE: begin
                  acc <= step_acc;
                  if (step_hit)
                     state <= IDLE;
               end
               default: begin
                  state <= IDLE;
                  acc   <= '0;
               end
            endcase
         end
      end
   end

endmodule
